ysyx_22041211_dsram_resp: RTL and testbench
===========================================

# ysyx_22041211_dsram_resp

Data-side memory responder for the LSU. It sits at the far end of the LSU's load/store port. It accepts one read or write request per valid/ready handshake and applies byte masks against an internal word array. After a fixed, parameterised latency it returns a registered response: raw zero-extended read data plus an error flag. Sign extension stays in the LSU.

## Interface
- `ADDR_LEN`, 32: request address width.
- `DATA_LEN`, 32: data width; only 32 is supported.
- `DEPTH_LOG2`, 12: array holds 2^DEPTH_LOG2 words.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 2: cycles from request acceptance to `resp_valid` (legal range 1..15).

Ports:
- `clk` input 1: sole clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_addr` input ADDR_LEN: byte address.
- `req_wen` input 1: write request.
- `req_ren` input 1: read request.
- `req_wdata` input DATA_LEN: store data, aligned to bit 0.
- `req_wmask` input 8: 8'h01 byte, 8'h03 half, 8'h0F word; bits [7:4] ignored.
- `req_rmask` input 8: same encoding for loads.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: LSU accepts response.
- `resp_rdata` output DATA_LEN: loaded bytes at bit 0, zero-filled above the mask width.
- `resp_err` output 1: access fault.

## Operation
- FSM has three states: IDLE, BUSY, RESP. Reset forces IDLE.
- `req_ready` = (state == IDLE) && `rst`. It is 0 while reset is asserted.
- **Accept** happens on a rising edge with `req_valid && req_ready`. On accept, `req_addr`, the masks, the enables and the data are latched.
- **Word index and offset:** word index = (`req_addr` − BASE_ADDR) >> 2; byte offset = `req_addr[1:0]`.
- **Write:** on the accept edge, byte lanes (wmask[3:0] << offset) of the indexed word take (wdata << 8*offset). Other lanes are unchanged.
- **Read:** sampled at the accept edge, in the same cycle as any write, using the pre-write contents. The result is the word >> 8*offset, ANDed with the rmask byte lanes expanded to bits.
- **Both enables set:** treated as a write; `resp_rdata` = 0.
- **Neither enable set:** null request; completes normally with `resp_rdata` = 0 and `resp_err` = 0.
- **Transition out of IDLE on accept:** go to RESP if LATENCY == 1. Otherwise load a 4-bit counter with LATENCY−2 and go to BUSY.
- **BUSY:** decrement the counter each cycle. When it reads 0, go to RESP at the next edge.
- **RESP:** `resp_valid` = 1. `resp_rdata` and `resp_err` are held stable until `resp_ready`. The handshake returns the FSM to IDLE.
- No request is accepted in the cycle the response completes.
- **Reset mid-operation:** the FSM returns to IDLE and the response is dropped. A write already committed at its accept edge stays committed. Array contents are never reset.

## Timing
- **Reset values:** `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `req_ready` 0 during reset and 1 in the first cycle after.
- **Latency:** accept at edge N gives `resp_valid` high from edge N+LATENCY.
- `resp_valid` deasserts at the edge after `resp_ready` is sampled high in RESP.
- `req_ready` rises in the cycle after that edge.
- **Throughput:** at most one transaction per LATENCY+1 cycles when `resp_ready` is held high.
- All outputs are registered except `req_ready`, which is decoded from state and `rst`.
- No combinational path runs from any request input to any response output.

## Configuration
- `YSYX_22041211_DSRAM_ERR_EN` defined:
  - `resp_err` = 1 when the word index falls outside the array.
  - `resp_err` = 1 when offset plus mask width exceeds 4 bytes (half at offset 3, word at offset ≠ 0).
  - On error the write is suppressed and `resp_rdata` = 0.
- Undefined:
  - `resp_err` tied 0.
  - Word index wraps modulo 2^DEPTH_LOG2.
  - Misaligned lanes past byte 3 are silently dropped.

## Test plan
- Write 32'hDEAD_BEEF with wmask 8'h0F at 32'h8000_0010, then read word at the same address (LATENCY 2) → `resp_valid` exactly 2 cycles after each accept; read `resp_rdata` = 32'hDEAD_BEEF, `resp_err` = 0.
- Byte write 32'h0000_00A5, wmask 8'h01, to 32'h8000_0013 over that word, then word read → 32'hA5AD_BEEF. Half read at 32'h8000_0012 → 32'h0000_A5AD.
- Hold `resp_ready` = 0 for 5 cycles in RESP → `resp_valid` and data stable throughout, `req_ready` = 0. Raise `resp_ready` → `req_ready` = 1 two edges later.
- With ERR_EN: word read at 32'h8000_0002, or at BASE_ADDR + 4·2^DEPTH_LOG2 → `resp_err` = 1, `resp_rdata` = 0. A write to those addresses leaves the array unchanged.
- Assert `rst` = 0 while in BUSY → the next cycle shows `resp_valid` = 0 and state IDLE. After release, `req_ready` = 1 and a new read completes normally.
- LATENCY = 1 build: back-to-back reads with `resp_ready` = 1 → one accept every 2 cycles, each response 1 cycle after its accept.

Source files
------------

// File: rtl/ysyx_22041211_dsram_resp_if.sv
// LSU <-> data-side memory responder bus.
//   master : LSU side; drives the request fields and resp_ready.
//   slave  : responder side; drives req_ready and the response fields.
// Signals:
//   req_valid/req_ready          request handshake
//   req_addr                     byte address
//   req_wen/req_ren              write / read enables
//   req_wdata, req_wmask         store data (aligned to bit 0) and size mask
//   req_rmask                    load size mask
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_err         zero-extended load data and access fault
interface ysyx_22041211_dsram_resp_if #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_LEN-1:0] req_addr;
  logic                req_wen;
  logic                req_ren;
  logic [DATA_LEN-1:0] req_wdata;
  logic [7:0]          req_wmask;
  logic [7:0]          req_rmask;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_LEN-1:0] resp_rdata;
  logic                resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_ren, req_wdata, req_wmask, req_rmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_ren, req_wdata, req_wmask, req_rmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_22041211_dsram_resp.sv
// Data-side memory responder for the LSU.
// Accepts one read/write per request handshake, applies byte masks against an internal word
// array and, LATENCY cycles after acceptance, presents a registered response holding the raw
// zero-extended load data and an error flag. Sign extension is left to the LSU.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : slave side of ysyx_22041211_dsram_resp_if (request + response handshakes)
// Configuration:
//   YSYX_22041211_DSRAM_ERR_EN defined   -> out-of-range index or lanes crossing byte 3 raise
//                                           resp_err, suppress the write and zero the data.
//   YSYX_22041211_DSRAM_ERR_EN undefined -> resp_err is 0, the index wraps modulo the depth and
//                                           lanes past byte 3 are dropped.
module ysyx_22041211_dsram_resp #(
  parameter int unsigned          ADDR_LEN   = 32,
  parameter int unsigned          DATA_LEN   = 32,
  parameter int unsigned          DEPTH_LOG2 = 12,
  parameter logic [ADDR_LEN-1:0]  BASE_ADDR  = ADDR_LEN'(32'h8000_0000),
  parameter int unsigned          LATENCY    = 2
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_22041211_dsram_resp_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  // BUSY lasts LATENCY-1 cycles; the counter starts at LATENCY-2 and leaves on zero.
  localparam logic [3:0] CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         Lat1    = (LATENCY == 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                resp_valid_q;
  logic [DATA_LEN-1:0] rdata_q;
  logic                err_q;

  logic [DATA_LEN-1:0] mem [2**DEPTH_LOG2];

  logic                  accept;
  logic [ADDR_LEN-1:0]   off_addr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            offset;
  logic                  is_wr;
  logic                  is_rd;
  logic [3:0]            wr_lanes;
  logic [DATA_LEN-1:0]   wr_data;
  logic [DATA_LEN-1:0]   rd_word;
  logic [DATA_LEN-1:0]   rd_bits;
  logic [DATA_LEN-1:0]   rd_val;
  logic                  req_err;
  logic                  unused_mask;

  assign bus.req_ready  = (state_q == StIdle) && rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid && bus.req_ready;

  // Only the low nibble of each mask selects lanes.
  assign unused_mask = ^{bus.req_wmask[7:4], bus.req_rmask[7:4]};

  always_comb begin
    off_addr = bus.req_addr - BASE_ADDR;
    idx      = off_addr[DEPTH_LOG2+1:2];
    offset   = off_addr[1:0];
    is_wr    = bus.req_wen;
    is_rd    = bus.req_ren && !bus.req_wen;  // both set counts as a write
    // 4-bit lane vector: lanes shifted past byte 3 fall off the top
    wr_lanes = bus.req_wmask[3:0] << offset;
    wr_data  = bus.req_wdata << {offset, 3'b000};
    rd_word  = mem[idx];
    rd_bits  = '0;
    for (int b = 0; b < 4; b++) begin
      rd_bits[8*b +: 8] = {8{bus.req_rmask[b]}};
    end
    rd_val   = (rd_word >> {offset, 3'b000}) & rd_bits;
  end

`ifdef YSYX_22041211_DSRAM_ERR_EN
  logic [3:0] act_mask;
  logic [7:0] span;
  logic       oob;
  logic       misalign;

  always_comb begin
    act_mask = is_wr ? bus.req_wmask[3:0] : bus.req_rmask[3:0];
    span     = {4'b0000, act_mask} << offset;
    misalign = |span[7:4];
    // Addresses below BASE_ADDR wrap to large offsets and land here too.
    oob      = |off_addr[ADDR_LEN-1:DEPTH_LOG2+2];
    req_err  = (is_wr || is_rd) && (oob || misalign);
  end
`else
  logic unused_hi;

  assign req_err   = 1'b0;
  assign unused_hi = ^off_addr[ADDR_LEN-1:DEPTH_LOG2+2];
`endif

  // Array is never reset; a write commits on its accept edge regardless of later resets.
  always_ff @(posedge clk) begin
    if (accept && is_wr && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_lanes[b]) begin
          mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // Read uses pre-write contents, captured now and held until the response completes.
            rdata_q <= (is_rd && !req_err) ? rd_val : '0;
            err_q   <= req_err;
            if (Lat1) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
            end else begin
              cnt_q   <= CntInit;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          if (cnt_q == 4'd0) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_dsram_resp.sv
module tb_ysyx_22041211_dsram_resp;

  localparam int unsigned LAT = 2;

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic [7:0]  rmask;
    logic [31:0] exp_d;
    logic        exp_e;
    int          hold;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic        e;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  sb_t         sb_q[$];
  logic [31:0] sb_b[$];
  vec_t        vecs[$];

  always #5 clk = ~clk;

  ysyx_22041211_dsram_resp_if #(.ADDR_LEN(32), .DATA_LEN(32)) a_if ();
  ysyx_22041211_dsram_resp_if #(.ADDR_LEN(32), .DATA_LEN(32)) b_if ();

  ysyx_22041211_dsram_resp #(
    .ADDR_LEN(32), .DATA_LEN(32), .DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(LAT)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(a_if.slave)
  );

  ysyx_22041211_dsram_resp #(
    .ADDR_LEN(32), .DATA_LEN(32), .DEPTH_LOG2(4), .BASE_ADDR(32'h8000_0000), .LATENCY(1)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(b_if.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t wr(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [7:0] wmask, input logic exp_e);
    return '{nm, addr, 1'b1, 1'b0, wdata, wmask, 8'h00, 32'h0, exp_e, 0};
  endfunction

  function automatic vec_t rd(input string nm, input logic [31:0] addr, input logic [7:0] rmask,
                              input logic [31:0] exp_d, input logic exp_e, input int hold);
    return '{nm, addr, 1'b0, 1'b1, 32'h0, 8'h00, rmask, exp_d, exp_e, hold};
  endfunction

  // One complete transaction on DUT A: request, latency check, scoreboard compare, completion.
  task automatic txn(input vec_t v);
    int  cyc;
    sb_t e;
    sb_q.push_back('{v.nm, v.exp_d, v.exp_e});
    a_if.req_addr  = v.addr;
    a_if.req_wen   = v.wen;
    a_if.req_ren   = v.ren;
    a_if.req_wdata = v.wdata;
    a_if.req_wmask = v.wmask;
    a_if.req_rmask = v.rmask;
    a_if.req_valid = 1'b1;
    cyc = 0;
    while (!a_if.req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({v.nm, "_req_ready"}, {31'b0, a_if.req_ready}, 32'd1);
    @(posedge clk); #1;
    a_if.req_valid = 1'b0;
    a_if.req_wen   = 1'b0;
    a_if.req_ren   = 1'b0;
    cyc = 0;
    while (!a_if.resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    // Visible after edge N+LAT-1, i.e. sampled high at edge N+LAT.
    chk({v.nm, "_latency"}, 32'(cyc), 32'(LAT - 1));
    if (sb_q.size() == 0) begin
      chk({v.nm, "_sb_empty"}, 32'd0, 32'd1);
      e = '{v.nm, 32'h0, 1'b0};
    end else begin
      e = sb_q.pop_front();
    end
    chk({e.nm, "_rdata"}, a_if.resp_rdata, e.d);
    chk({e.nm, "_err"}, {31'b0, a_if.resp_err}, {31'b0, e.e});
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk({e.nm, "_hold_valid"}, {31'b0, a_if.resp_valid}, 32'd1);
      chk({e.nm, "_hold_rdata"}, a_if.resp_rdata, e.d);
      chk({e.nm, "_hold_req_ready"}, {31'b0, a_if.req_ready}, 32'd0);
    end
    a_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    a_if.resp_ready = 1'b0;
    chk({e.nm, "_valid_drop"}, {31'b0, a_if.resp_valid}, 32'd0);
    chk({e.nm, "_ready_back"}, {31'b0, a_if.req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    int accepts;
    logic [31:0] eb;

    a_if.req_valid = 0; a_if.req_addr = 0; a_if.req_wen = 0; a_if.req_ren = 0;
    a_if.req_wdata = 0; a_if.req_wmask = 0; a_if.req_rmask = 0; a_if.resp_ready = 0;
    b_if.req_valid = 0; b_if.req_addr = 0; b_if.req_wen = 0; b_if.req_ren = 0;
    b_if.req_wdata = 0; b_if.req_wmask = 0; b_if.req_rmask = 0; b_if.resp_ready = 0;

    vecs.push_back(wr("w_word",        32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 1'b0));
    vecs.push_back(rd("r_word",        32'h8000_0010, 8'h0F, 32'hDEAD_BEEF, 1'b0, 0));
    vecs.push_back(wr("w_byte3",       32'h8000_0013, 32'h0000_00A5, 8'h01, 1'b0));
    vecs.push_back(rd("r_word_hold",   32'h8000_0010, 8'h0F, 32'hA5AD_BEEF, 1'b0, 5));
    vecs.push_back(rd("r_half2",       32'h8000_0012, 8'h03, 32'h0000_A5AD, 1'b0, 0));
    vecs.push_back(rd("r_byte1",       32'h8000_0011, 8'h01, 32'h0000_00BE, 1'b0, 0));
    vecs.push_back(wr("w_word14",      32'h8000_0014, 32'h1122_3344, 8'h0F, 1'b0));
    vecs.push_back(wr("w_half16",      32'h8000_0016, 32'h0000_ABCD, 8'h03, 1'b0));
    vecs.push_back(rd("r_word14",      32'h8000_0014, 8'h0F, 32'hABCD_3344, 1'b0, 0));
    vecs.push_back('{"both_en", 32'h8000_0018, 1'b1, 1'b1, 32'hCAFE_F00D, 8'h0F, 8'h0F,
                     32'h0, 1'b0, 0});
    vecs.push_back(rd("r_after_both",  32'h8000_0018, 8'h0F, 32'hCAFE_F00D, 1'b0, 0));
    vecs.push_back('{"null_req", 32'h8000_0018, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'h0F, 8'h0F,
                     32'h0, 1'b0, 0});
    vecs.push_back(rd("r_after_null",  32'h8000_0018, 8'h0F, 32'hCAFE_F00D, 1'b0, 0));
    vecs.push_back(rd("r_mask_hi_ign", 32'h8000_0018, 8'hF1, 32'h0000_000D, 1'b0, 0));
`ifdef YSYX_22041211_DSRAM_ERR_EN
    vecs.push_back(rd("e_r_misalign",  32'h8000_0002, 8'h0F, 32'h0, 1'b1, 0));
    vecs.push_back(rd("e_r_oob",       32'h8000_4000, 8'h0F, 32'h0, 1'b1, 0));
    vecs.push_back(wr("e_w_oob",       32'h8000_4010, 32'h55AA_55AA, 8'h0F, 1'b1));
    vecs.push_back(wr("e_w_word_mis",  32'h8000_0012, 32'h0000_0000, 8'h0F, 1'b1));
    vecs.push_back(wr("e_w_half_off3", 32'h8000_0013, 32'h0000_FFFF, 8'h03, 1'b1));
    vecs.push_back(rd("e_r_unchanged", 32'h8000_0010, 8'h0F, 32'hA5AD_BEEF, 1'b0, 0));
    vecs.push_back(rd("e_r_byte_off3", 32'h8000_0013, 8'h01, 32'h0000_00A5, 1'b0, 0));
`else
    vecs.push_back(wr("d_w_wrap",      32'h8000_4010, 32'h55AA_55AA, 8'h0F, 1'b0));
    vecs.push_back(rd("d_r_wrapped",   32'h8000_0010, 8'h0F, 32'h55AA_55AA, 1'b0, 0));
    vecs.push_back(wr("d_w_zero20",    32'h8000_0020, 32'h0000_0000, 8'h0F, 1'b0));
    vecs.push_back(wr("d_w_word_off2", 32'h8000_0022, 32'hFFFF_FFFF, 8'h0F, 1'b0));
    vecs.push_back(rd("d_r_word20",    32'h8000_0020, 8'h0F, 32'hFFFF_0000, 1'b0, 0));
    vecs.push_back(rd("d_r_word_off2", 32'h8000_0022, 8'h0F, 32'h0000_FFFF, 1'b0, 0));
    vecs.push_back(wr("d_w_half_off3", 32'h8000_0023, 32'h0000_1234, 8'h03, 1'b0));
    vecs.push_back(rd("d_r_word20b",   32'h8000_0020, 8'h0F, 32'h34FF_0000, 1'b0, 0));
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'b0, a_if.resp_valid}, 32'd0);
    chk("rst_resp_rdata", a_if.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, a_if.resp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, a_if.req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_req_ready", {31'b0, a_if.req_ready}, 32'd1);

    foreach (vecs[i]) txn(vecs[i]);

    // Reset while BUSY: response dropped, committed write kept.
    a_if.req_addr  = 32'h8000_0030;
    a_if.req_wen   = 1'b1;
    a_if.req_wdata = 32'h0BAD_F00D;
    a_if.req_wmask = 8'h0F;
    a_if.req_valid = 1'b1;
    chk("busy_pre_ready", {31'b0, a_if.req_ready}, 32'd1);
    @(posedge clk); #1;
    a_if.req_valid = 1'b0;
    a_if.req_wen   = 1'b0;
    chk("busy_valid_low", {31'b0, a_if.resp_valid}, 32'd0);
    chk("busy_ready_low", {31'b0, a_if.req_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", {31'b0, a_if.resp_valid}, 32'd0);
    chk("midrst_rdata", a_if.resp_rdata, 32'd0);
    chk("midrst_req_ready", {31'b0, a_if.req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_release_ready", {31'b0, a_if.req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_resp_dropped", {31'b0, a_if.resp_valid}, 32'd0);
    txn(rd("r_after_midrst", 32'h8000_0030, 8'h0F, 32'h0BAD_F00D, 1'b0, 0));

    // LATENCY=1 instance: held requests and resp_ready -> accept every 2 cycles.
    b_if.req_addr   = 32'h8000_0004;
    b_if.req_wen    = 1'b1;
    b_if.req_wdata  = 32'h1357_9BDF;
    b_if.req_wmask  = 8'h0F;
    b_if.req_rmask  = 8'h0F;
    b_if.req_valid  = 1'b1;
    b_if.resp_ready = 1'b1;
    accepts = 0;
    for (int c = 0; c < 8; c++) begin
      acc = b_if.req_valid && b_if.req_ready;
      if (acc) begin
        accepts++;
        sb_b.push_back(b_if.req_wen ? 32'h0 : 32'h1357_9BDF);
      end
      @(posedge clk); #1;
      if (acc) begin
        chk("lat1_resp_valid", {31'b0, b_if.resp_valid}, 32'd1);
        chk("lat1_req_ready_low", {31'b0, b_if.req_ready}, 32'd0);
        eb = (sb_b.size() != 0) ? sb_b.pop_front() : 32'hFFFF_FFFF;
        chk("lat1_rdata", b_if.resp_rdata, eb);
        b_if.req_wen = 1'b0;
        b_if.req_ren = 1'b1;
      end else begin
        chk("lat1_gap_valid", {31'b0, b_if.resp_valid}, 32'd0);
        chk("lat1_gap_ready", {31'b0, b_if.req_ready}, 32'd1);
      end
    end
    chk("lat1_accept_count", 32'(accepts), 32'd4);
    b_if.req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
